wb_stage: RTL and testbench

Writeback stage of the five-stage pipeline. Registers the MEM-stage result, selects and load-aligns the writeback value, and drives the register file write port (load/dest/in), which the register file also bypasses to decode. Holds state under pipeline stall and counts retired instructions for performance monitoring.

---
 rtl/wb_stage.sv | 140 ++++++++++++++
 tb/tb_wb_stage.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : wb_stage
// Description : Pipeline writeback stage. Registers the MEM result, load-aligns
//               and selects the writeback value, drives the register file
//               write port and counts retired instructions.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_stage #(
    parameter int RETIRE_W = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                mem_valid,
    input  logic                mem_regwrite,
    input  logic [4:0]          mem_rd,
    input  logic [2:0]          mem_wb_sel,
    input  logic [2:0]          mem_funct3,
    input  logic [31:0]         mem_alu_out,
    input  logic [31:0]         mem_pc,
    input  logic [31:0]         mem_u_imm,
    input  logic                mem_br_en,
    input  logic [31:0]         mem_rdata,
    output logic                rf_load,
    output logic [4:0]          rf_dest,
    output logic [31:0]         rf_in,
    output logic                wb_valid,
    output logic [31:0]         wb_pc,
    output logic [RETIRE_W-1:0] retire_count
);

    localparam logic [2:0] SEL_ALU  = 3'd0;
    localparam logic [2:0] SEL_LOAD = 3'd1;
    localparam logic [2:0] SEL_PC4  = 3'd2;
    localparam logic [2:0] SEL_UIMM = 3'd3;
    localparam logic [2:0] SEL_BREN = 3'd4;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [RETIRE_W-1:0] RETIRE_ONE = {{(RETIRE_W-1){1'b0}}, 1'b1};

    // WB pipeline register
    logic        wb_v;
    logic        wb_regwrite;
    logic [4:0]  wb_rd;
    logic [2:0]  wb_sel;
    logic [2:0]  wb_funct3;
    logic [31:0] wb_alu_out;
    logic [31:0] wb_pc_q;
    logic [31:0] wb_u_imm;
    logic        wb_br_en;
    logic [31:0] wb_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_v         <= 1'b0;
            wb_regwrite  <= 1'b0;
            wb_rd        <= 5'd0;
            wb_sel       <= 3'd0;
            wb_funct3    <= 3'd0;
            wb_alu_out   <= 32'd0;
            wb_pc_q      <= 32'd0;
            wb_u_imm     <= 32'd0;
            wb_br_en     <= 1'b0;
            wb_rdata     <= 32'd0;
            retire_count <= '0;
        end else if (!stall) begin
            wb_v        <= mem_valid;
            wb_regwrite <= mem_regwrite;
            wb_rd       <= mem_rd;
            wb_sel      <= mem_wb_sel;
            wb_funct3   <= mem_funct3;
            wb_alu_out  <= mem_alu_out;
            wb_pc_q     <= mem_pc;
            wb_u_imm    <= mem_u_imm;
            wb_br_en    <= mem_br_en;
            wb_rdata    <= mem_rdata;
            if (mem_valid) begin
                retire_count <= retire_count + RETIRE_ONE;
            end
        end
    end

    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_data;
    logic [31:0] sel_data;

    always_comb begin
        load_byte = 8'd0;
        unique case (wb_alu_out[1:0])
            2'd0: load_byte = wb_rdata[7:0];
            2'd1: load_byte = wb_rdata[15:8];
            2'd2: load_byte = wb_rdata[23:16];
            2'd3: load_byte = wb_rdata[31:24];
            default: load_byte = 8'd0;
        endcase
    end

    // Halfword loads ignore alu_out[0]; misalignment is not trapped here.
    assign load_half = wb_alu_out[1] ? wb_rdata[31:16] : wb_rdata[15:0];

    always_comb begin
        load_data = wb_rdata;
        case (wb_funct3)
            F3_LB:   load_data = {{24{load_byte[7]}}, load_byte};
            F3_LBU:  load_data = {24'd0, load_byte};
            F3_LH:   load_data = {{16{load_half[15]}}, load_half};
            F3_LHU:  load_data = {16'd0, load_half};
            F3_LW:   load_data = wb_rdata;
            default: load_data = wb_rdata;
        endcase
    end

    always_comb begin
        sel_data = 32'd0;
        case (wb_sel)
            SEL_ALU:  sel_data = wb_alu_out;
            SEL_LOAD: sel_data = load_data;
            SEL_PC4:  sel_data = wb_pc_q + 32'd4;
            SEL_UIMM: sel_data = wb_u_imm;
            SEL_BREN: sel_data = {31'd0, wb_br_en};
            default:  sel_data = 32'd0;
        endcase
    end

    // Held outputs under stall keep the regfile bypass to decode valid.
    assign rf_load  = wb_v & wb_regwrite & (wb_rd != 5'd0);
    assign rf_dest  = rf_load ? wb_rd : 5'd0;
    assign rf_in    = rf_load ? sel_data : 32'd0;
    assign wb_valid = wb_v;
    assign wb_pc    = wb_pc_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_stage
// Description : Directed, table-driven self-checking bench for wb_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_stage;

    localparam int RETIRE_W = 64;

    logic                clk = 1'b0;
    logic                rst;
    logic                stall;
    logic                mem_valid;
    logic                mem_regwrite;
    logic [4:0]          mem_rd;
    logic [2:0]          mem_wb_sel;
    logic [2:0]          mem_funct3;
    logic [31:0]         mem_alu_out;
    logic [31:0]         mem_pc;
    logic [31:0]         mem_u_imm;
    logic                mem_br_en;
    logic [31:0]         mem_rdata;
    logic                rf_load;
    logic [4:0]          rf_dest;
    logic [31:0]         rf_in;
    logic                wb_valid;
    logic [31:0]         wb_pc;
    logic [RETIRE_W-1:0] retire_count;

    wb_stage #(.RETIRE_W(RETIRE_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .mem_valid    (mem_valid),
        .mem_regwrite (mem_regwrite),
        .mem_rd       (mem_rd),
        .mem_wb_sel   (mem_wb_sel),
        .mem_funct3   (mem_funct3),
        .mem_alu_out  (mem_alu_out),
        .mem_pc       (mem_pc),
        .mem_u_imm    (mem_u_imm),
        .mem_br_en    (mem_br_en),
        .mem_rdata    (mem_rdata),
        .rf_load      (rf_load),
        .rf_dest      (rf_dest),
        .rf_in        (rf_in),
        .wb_valid     (wb_valid),
        .wb_pc        (wb_pc),
        .retire_count (retire_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [63:0] exp_count = 64'd0;

    typedef struct {
        logic [2:0]  sel;
        logic [2:0]  f3;
        logic [31:0] alu;
        logic [31:0] pc;
        logic [31:0] uimm;
        logic        br;
        logic [31:0] rdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock; the bench's own retire model advances alongside it.
    task automatic tick();
        if (rst) exp_count = 64'd0;
        else if (!stall && mem_valid) exp_count = exp_count + 64'd1;
        @(posedge clk);
        #1;
    endtask

    task automatic set_mem(input logic v, input logic rw, input logic [4:0] rd,
                           input logic [2:0] sel, input logic [2:0] f3,
                           input logic [31:0] alu, input logic [31:0] pc,
                           input logic [31:0] uimm, input logic br,
                           input logic [31:0] rdata);
        mem_valid = v; mem_regwrite = rw; mem_rd = rd; mem_wb_sel = sel;
        mem_funct3 = f3; mem_alu_out = alu; mem_pc = pc; mem_u_imm = uimm;
        mem_br_en = br; mem_rdata = rdata;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".rf_load"}, 64'(rf_load), 64'd0);
        chk({tag, ".rf_dest"}, 64'(rf_dest), 64'd0);
        chk({tag, ".rf_in"}, 64'(rf_in), 64'd0);
        chk({tag, ".wb_valid"}, 64'(wb_valid), 64'd0);
        chk({tag, ".wb_pc"}, 64'(wb_pc), 64'd0);
        chk({tag, ".count"}, retire_count, 64'd0);
    endtask

    initial begin
        logic [31:0] held_in;
        logic [4:0]  held_dest;

        vecs[0]  = '{3'd1, 3'b000, 32'h1000, 32'h40, 32'h0, 1'b0, 32'h80FF7F01, 32'h00000001};
        vecs[1]  = '{3'd1, 3'b000, 32'h1001, 32'h44, 32'h0, 1'b0, 32'h80FF7F01, 32'h0000007F};
        vecs[2]  = '{3'd1, 3'b000, 32'h1002, 32'h48, 32'h0, 1'b0, 32'h80FF7F01, 32'hFFFFFFFF};
        vecs[3]  = '{3'd1, 3'b000, 32'h1003, 32'h4C, 32'h0, 1'b0, 32'h80FF7F01, 32'hFFFFFF80};
        vecs[4]  = '{3'd1, 3'b100, 32'h1003, 32'h50, 32'h0, 1'b0, 32'h80FF7F01, 32'h00000080};
        vecs[5]  = '{3'd1, 3'b001, 32'h1002, 32'h54, 32'h0, 1'b0, 32'h80FF7F01, 32'hFFFF80FF};
        vecs[6]  = '{3'd1, 3'b101, 32'h1000, 32'h58, 32'h0, 1'b0, 32'h80FF7F01, 32'h00007F01};
        vecs[7]  = '{3'd1, 3'b010, 32'h1003, 32'h5C, 32'h0, 1'b0, 32'h80FF7F01, 32'h80FF7F01};
        vecs[8]  = '{3'd1, 3'b001, 32'h1003, 32'h60, 32'h0, 1'b0, 32'h80FF7F01, 32'hFFFF80FF};
        vecs[9]  = '{3'd1, 3'b100, 32'h1001, 32'h64, 32'h0, 1'b0, 32'h80FF7F01, 32'h0000007F};
        vecs[10] = '{3'd1, 3'b011, 32'h1001, 32'h68, 32'h0, 1'b0, 32'h80FF7F01, 32'h80FF7F01};
        vecs[11] = '{3'd2, 3'b000, 32'h0, 32'hFFFFFFFC, 32'h0, 1'b0, 32'h0, 32'h00000000};
        vecs[12] = '{3'd3, 3'b000, 32'h0, 32'hFFFFFFFC, 32'h12345000, 1'b0, 32'h0, 32'h12345000};
        vecs[13] = '{3'd4, 3'b000, 32'h0, 32'hFFFFFFFC, 32'h0, 1'b1, 32'h0, 32'h00000001};
        vecs[14] = '{3'd5, 3'b000, 32'hDEAD, 32'h70, 32'hBEEF, 1'b1, 32'h1234, 32'h00000000};
        vecs[15] = '{3'd0, 3'b010, 32'hA5A5A5A5, 32'h74, 32'h0, 1'b0, 32'h0, 32'hA5A5A5A5};

        rst = 1'b1; stall = 1'b0;
        set_mem(1'b1, 1'b1, 5'd7, 3'd0, 3'd0, 32'h77, 32'h100, 32'h0, 1'b0, 32'h0);
        tick(); tick();
        chk_all_zero("reset");
        rst = 1'b0;

        // Back-to-back ALU writes
        for (int i = 1; i <= 3; i++) begin
            set_mem(1'b1, 1'b1, 5'(i), 3'd0, 3'd0, 32'h11 * i, 32'h200 + 32'(4 * i), 32'h0, 1'b0, 32'h0);
            tick();
            chk("alu.rf_load", 64'(rf_load), 64'd1);
            chk("alu.rf_dest", 64'(rf_dest), 64'(i));
            chk("alu.rf_in", 64'(rf_in), 64'(32'h11 * i));
        end
        chk("alu.count", retire_count, 64'd3);

        // Select and load-alignment vectors
        for (int i = 0; i < 16; i++) begin
            set_mem(1'b1, 1'b1, 5'(i + 8), vecs[i].sel, vecs[i].f3, vecs[i].alu,
                    vecs[i].pc, vecs[i].uimm, vecs[i].br, vecs[i].rdata);
            tick();
            chk($sformatf("vec%0d.rf_in", i), 64'(rf_in), 64'(vecs[i].exp));
            chk($sformatf("vec%0d.rf_dest", i), 64'(rf_dest), 64'(i + 8));
            chk($sformatf("vec%0d.wb_pc", i), 64'(wb_pc), 64'(vecs[i].pc));
        end
        chk("vec.count", retire_count, exp_count);

        // Stall with a lw to x5 held in WB
        set_mem(1'b1, 1'b1, 5'd5, 3'd1, 3'b010, 32'h300, 32'h400, 32'h0, 1'b0, 32'hCAFEBABE);
        tick();
        held_in = rf_in; held_dest = rf_dest;
        chk("stall.entry_in", 64'(held_in), 64'hCAFEBABE);
        chk("stall.entry_dest", 64'(held_dest), 64'd5);
        stall = 1'b1;
        for (int c = 0; c < 4; c++) begin
            set_mem(1'b1, 1'b1, 5'd6, 3'd0, 3'd0, 32'h66 + 32'(c), 32'h404, 32'h0, 1'b0, 32'h0);
            tick();
            chk($sformatf("stall%0d.rf_load", c), 64'(rf_load), 64'd1);
            chk($sformatf("stall%0d.rf_dest", c), 64'(rf_dest), 64'd5);
            chk($sformatf("stall%0d.rf_in", c), 64'(rf_in), 64'hCAFEBABE);
            chk($sformatf("stall%0d.count", c), retire_count, exp_count);
        end
        stall = 1'b0;
        set_mem(1'b1, 1'b1, 5'd6, 3'd0, 3'd0, 32'h66, 32'h404, 32'h0, 1'b0, 32'h0);
        tick();
        chk("unstall.rf_dest", 64'(rf_dest), 64'd6);
        chk("unstall.rf_in", 64'(rf_in), 64'h66);
        chk("unstall.count", retire_count, exp_count);

        // Write to x0: retired but not written
        set_mem(1'b1, 1'b1, 5'd0, 3'd0, 3'd0, 32'h99, 32'h408, 32'h0, 1'b0, 32'h0);
        tick();
        chk("x0.rf_load", 64'(rf_load), 64'd0);
        chk("x0.rf_in", 64'(rf_in), 64'd0);
        chk("x0.wb_valid", 64'(wb_valid), 64'd1);
        chk("x0.count", retire_count, exp_count);

        // Bubble
        set_mem(1'b0, 1'b1, 5'd9, 3'd0, 3'd0, 32'h55, 32'h40C, 32'h0, 1'b0, 32'h0);
        tick();
        chk("bubble.rf_load", 64'(rf_load), 64'd0);
        chk("bubble.wb_valid", 64'(wb_valid), 64'd0);
        chk("bubble.count", retire_count, exp_count);

        // Valid but no regwrite
        set_mem(1'b1, 1'b0, 5'd9, 3'd0, 3'd0, 32'h55, 32'h410, 32'h0, 1'b0, 32'h0);
        tick();
        chk("norw.rf_load", 64'(rf_load), 64'd0);
        chk("norw.wb_valid", 64'(wb_valid), 64'd1);

        // Reset while stalled with a valid instruction in WB
        set_mem(1'b1, 1'b1, 5'd12, 3'd0, 3'd0, 32'h1234, 32'h500, 32'h0, 1'b0, 32'h0);
        tick();
        chk("prerst.rf_load", 64'(rf_load), 64'd1);
        stall = 1'b1; rst = 1'b1;
        tick();
        chk_all_zero("rststall");
        rst = 1'b0; stall = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule
`default_nettype wire
